// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch bridge: FSM state codes,
// bus transfer size and the default NOP word.
package fetch_pkg;

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_REQ  = 2'd1;
    localparam logic [1:0]  ST_WAIT = 2'd2;
    localparam logic [1:0]  ST_DONE = 2'd3;

    localparam logic [1:0]  SIZE_WORD        = 2'b10;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    // Word-aligned bus address for a fetch PC (low two bits forced to zero)
    function automatic logic [31:0] word_addr(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_bridge.sv
// Fetch-side bridge between the MIPS pipeline and the SRAM-like instruction
// bus. One word read per PC, at most one request outstanding; stall_o holds
// the pipeline until the instruction is presented on inst_o.
// Optional feature macro: INST_ALIGN_CHECK_EN (misaligned PC raises adel_o
// instead of issuing a bus request).
module inst_fetch_bridge
    import fetch_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       pc_i,
    input  logic              adv_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              stall_o,
    output logic              adel_o,
    output logic              inst_req,
    output logic              inst_wr,
    output logic [1:0]        inst_size,
    output logic [31:0]       inst_addr,
    output logic [DATA_W-1:0] inst_wdata,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata
);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              discard_r;
    logic              discard_nxt_s;
    logic [DATA_W-1:0] inst_r;
    logic [DATA_W-1:0] inst_nxt_s;
    logic              adel_r;
    logic              adel_nxt_s;
    logic              req_r;
    logic              stall_r;
    logic [DATA_W-1:0] inst_out_r;
    logic              misaligned_s;

`ifdef INST_ALIGN_CHECK_EN
    assign misaligned_s = (pc_i[1:0] != 2'b00);
`else
    assign misaligned_s = 1'b0;
`endif

    // Next-state, discard flag, held instruction and address-error decode
    always_comb begin
        state_nxt_s   = state_r;
        discard_nxt_s = discard_r;
        inst_nxt_s    = inst_r;
        adel_nxt_s    = adel_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_REQ;
            end
            ST_REQ: begin
                if (misaligned_s) begin
                    // No bus request for a misaligned PC; a flush simply retries
                    if (flush_i) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_DONE;
                        inst_nxt_s  = NOP_INST;
                        adel_nxt_s  = 1'b1;
                    end
                end else if (inst_addr_ok) begin
                    state_nxt_s   = ST_WAIT;
                    discard_nxt_s = flush_i;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    if (discard_r || flush_i) begin
                        // Killed fetch: drop the data and re-request the current PC
                        state_nxt_s   = ST_REQ;
                        discard_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_DONE;
                        inst_nxt_s  = inst_rdata;
                        adel_nxt_s  = 1'b0;
                    end
                end else begin
                    discard_nxt_s = discard_r | flush_i;
                end
            end
            ST_DONE: begin
                // flush_i and adv_i both start the next fetch; flush wins by
                // the simple fact that the held word is never shown again
                if (flush_i || adv_i) begin
                    state_nxt_s = ST_REQ;
                    adel_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                discard_nxt_s = 1'b0;
                inst_nxt_s    = NOP_INST;
                adel_nxt_s    = 1'b0;
            end
        endcase
    end

    // FSM state, discard flag and held instruction registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            discard_r <= 1'b0;
            inst_r    <= NOP_INST;
        end else begin
            state_r   <= state_nxt_s;
            discard_r <= discard_nxt_s;
            inst_r    <= inst_nxt_s;
        end
    end

    // Outputs decoded from the next state so they leave the block on flops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_r      <= 1'b0;
            stall_r    <= 1'b1;
            inst_out_r <= NOP_INST;
            adel_r     <= 1'b0;
        end else begin
            req_r      <= (state_nxt_s == ST_REQ);
            stall_r    <= (state_nxt_s != ST_DONE);
            inst_out_r <= (state_nxt_s == ST_DONE) ? inst_nxt_s : NOP_INST;
            adel_r     <= adel_nxt_s;
        end
    end

    // Request is suppressed combinationally for a misaligned PC, since the
    // PC may only settle to its new value in the REQ cycle itself
    assign inst_req   = req_r & ~misaligned_s;
    assign inst_addr  = word_addr(pc_i);
    assign inst_wr    = 1'b0;
    assign inst_size  = SIZE_WORD;
    assign inst_wdata = {DATA_W{1'b0}};
    assign inst_o     = inst_out_r;
    assign stall_o    = stall_r;
    assign adel_o     = adel_r;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge. A small bus responder reacts to
// inst_req with chosen latencies; expected stall lengths, addresses and
// instruction words come from the fetch rules (latency arithmetic, masking).
module tb_inst_fetch_bridge;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc_i;
    logic        adv_i;
    logic        flush_i;
    logic [31:0] inst_o;
    logic        stall_o;
    logic        adel_o;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] held_q;

    always #5 clk = ~clk;

    inst_fetch_bridge dut (
        .clk(clk), .resetn(resetn), .pc_i(pc_i), .adv_i(adv_i), .flush_i(flush_i),
        .inst_o(inst_o), .stall_o(stall_o), .adel_o(adel_o),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
    );

    // Advance to just after the falling edge: sample point and input drive point
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; pc_i = 32'hbfc0_0000; adv_i = 1'b0; flush_i = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        tick(); tick();
        tests_run++; if (inst_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got %b want 0", inst_req); end
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL reset_stall got %b want 1", stall_o); end
        tests_run++; if (inst_o !== NOP) begin tests_failed++; $display("FAIL reset_inst got %h want %h", inst_o, NOP); end
        tests_run++; if (adel_o !== 1'b0) begin tests_failed++; $display("FAIL reset_adel got %b want 0", adel_o); end
        tests_run++; if ({inst_wr, inst_size, inst_wdata} !== {1'b0, 2'b10, 32'h0}) begin
            tests_failed++; $display("FAIL reset_consts got %b/%b/%h want 0/10/0", inst_wr, inst_size, inst_wdata); end
        resetn = 1'b1;
        tick();
        tests_run++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0000) begin
            tests_failed++; $display("FAIL reset_first_req got req=%b addr=%h want 1/bfc00000", inst_req, inst_addr); end
    endtask

    task automatic test_zero_wait();
        int stalls = 0;
        logic [31:0] p = pc_i;
        if (stall_o) stalls++;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        if (stall_o) stalls++;
        tests_run++; if (inst_req !== 1'b0) begin tests_failed++; $display("FAIL zw_wait_req got %b want 0", inst_req); end
        inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
        tick();
        inst_data_ok = 1'b0;
        if (stall_o) stalls++;
        tests_run++; if (stalls != 2) begin tests_failed++; $display("FAIL zw_stall_cycles got %0d want 2", stalls); end
        tests_run++; if (inst_o !== 32'h2408_0001) begin tests_failed++; $display("FAIL zw_inst got %h want 24080001", inst_o); end
        adv_i = 1'b1; pc_i = p + 32'd4;
        tick();
        adv_i = 1'b0;
        tests_run++; if (inst_req !== 1'b1 || inst_addr !== p + 32'd4 || inst_o !== NOP || stall_o !== 1'b1) begin
            tests_failed++; $display("FAIL zw_next_req got req=%b addr=%h inst=%h stall=%b want 1/%h/%h/1",
                                     inst_req, inst_addr, inst_o, stall_o, p + 32'd4, NOP); end
    endtask

    task automatic test_delayed();
        int req_cyc = 0, stall_cyc = 0, hs = 0, wait_cyc = 0, bad_addr = 0;
        logic [31:0] d = $urandom;
        for (int c = 0; c < 20; c++) begin
            if (!stall_o) break;
            stall_cyc++;
            if (inst_req) begin
                req_cyc++;
                if (inst_addr !== (pc_i & 32'hFFFF_FFFC)) bad_addr++;
                inst_addr_ok = (req_cyc == 4);
                inst_data_ok = 1'b0;
                if (inst_addr_ok) hs++;
            end else begin
                inst_addr_ok = 1'b0;
                if (hs == 1) wait_cyc++;
                inst_data_ok = (hs == 1 && wait_cyc == 2);
                inst_rdata   = inst_data_ok ? d : $urandom;
            end
            tick();
        end
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL dly_timeout stall got %b want 0", stall_o); end
        tests_run++; if (req_cyc != 4 || hs != 1 || bad_addr != 0) begin
            tests_failed++; $display("FAIL dly_req got cycles=%0d hs=%0d badaddr=%0d want 4/1/0", req_cyc, hs, bad_addr); end
        tests_run++; if (stall_cyc != 6) begin tests_failed++; $display("FAIL dly_stall got %0d want 6", stall_cyc); end
        tests_run++; if (inst_o !== d) begin tests_failed++; $display("FAIL dly_inst got %h want %h", inst_o, d); end
        held_q = d;
    endtask

    task automatic test_hold();
        int bad = 0;
        for (int h = 0; h < 5; h++) begin
            tick();
            if (inst_o !== held_q || stall_o !== 1'b0 || inst_req !== 1'b0) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
        adv_i = 1'b1; pc_i = 32'h8000_0100;
        tick();
        adv_i = 1'b0;
        tests_run++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0100 || stall_o !== 1'b1) begin
            tests_failed++; $display("FAIL hold_adv got req=%b addr=%h stall=%b want 1/80000100/1", inst_req, inst_addr, stall_o); end
    endtask

    task automatic test_spurious_data_ok();
        logic [31:0] d = $urandom;
        inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_0001;
        tick();
        inst_data_ok = 1'b0;
        tests_run++; if (inst_req !== 1'b1 || stall_o !== 1'b1) begin
            tests_failed++; $display("FAIL spur_req got req=%b stall=%b want 1/1", inst_req, stall_o); end
        inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = d; tick();
        inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_0002; tick();
        inst_data_ok = 1'b0;
        tests_run++; if (inst_o !== d || stall_o !== 1'b0) begin
            tests_failed++; $display("FAIL spur_done got inst=%h stall=%b want %h/0", inst_o, stall_o, d); end
        adv_i = 1'b1; pc_i = 32'h8000_0200; tick(); adv_i = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] d = $urandom;
        // flush in REQ without acceptance: request simply continues at the new PC
        flush_i = 1'b1; pc_i = 32'h8000_1000; tick();
        tests_run++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_1000) begin
            tests_failed++; $display("FAIL fl_req_noack got req=%b addr=%h want 1/80001000", inst_req, inst_addr); end
        // flush together with acceptance: the returning word is discarded
        inst_addr_ok = 1'b1; pc_i = 32'h8000_2000; tick();
        inst_addr_ok = 1'b0; flush_i = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; tick(); inst_data_ok = 1'b0;
        tests_run++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_2000 || inst_o !== NOP || stall_o !== 1'b1) begin
            tests_failed++; $display("FAIL fl_req_ack got req=%b addr=%h inst=%h stall=%b want 1/80002000/%h/1",
                                     inst_req, inst_addr, inst_o, stall_o, NOP); end
        // flush while waiting, data arrives a cycle later
        inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
        flush_i = 1'b1; pc_i = 32'h8000_3000; tick(); flush_i = 1'b0;
        tests_run++; if (inst_req !== 1'b0 || stall_o !== 1'b1 || inst_o !== NOP) begin
            tests_failed++; $display("FAIL fl_wait got req=%b stall=%b inst=%h want 0/1/%h", inst_req, stall_o, inst_o, NOP); end
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; tick(); inst_data_ok = 1'b0;
        tests_run++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_3000 || inst_o === 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL fl_wait_drop got req=%b addr=%h inst=%h want 1/80003000/not deadbeef",
                                     inst_req, inst_addr, inst_o); end
        // flush in the same cycle as data_ok
        inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
        flush_i = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; pc_i = 32'h8000_4000; tick();
        flush_i = 1'b0; inst_data_ok = 1'b0;
        tests_run++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_4000 || inst_o !== NOP) begin
            tests_failed++; $display("FAIL fl_same got req=%b addr=%h inst=%h want 1/80004000/%h", inst_req, inst_addr, inst_o, NOP); end
        // deliver a clean word, then flush (with adv) in DONE
        inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = d; tick(); inst_data_ok = 1'b0;
        tests_run++; if (inst_o !== d || stall_o !== 1'b0) begin
            tests_failed++; $display("FAIL fl_deliver got inst=%h stall=%b want %h/0", inst_o, stall_o, d); end
        flush_i = 1'b1; adv_i = 1'b1; pc_i = 32'h8000_5000; tick(); flush_i = 1'b0; adv_i = 1'b0;
        tests_run++; if (inst_req !== 1'b1 || inst_o !== NOP || stall_o !== 1'b1 || inst_addr !== 32'h8000_5000) begin
            tests_failed++; $display("FAIL fl_done got req=%b inst=%h stall=%b addr=%h want 1/%h/1/80005000",
                                     inst_req, inst_o, stall_o, inst_addr, NOP); end
    endtask

    task automatic test_misalign();
        pc_i = 32'hbfc0_0002;
        #1;
`ifdef INST_ALIGN_CHECK_EN
        tests_run++; if (inst_req !== 1'b0) begin tests_failed++; $display("FAIL mis_noreq got %b want 0", inst_req); end
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        tests_run++; if (inst_req !== 1'b0 || stall_o !== 1'b1 || adel_o !== 1'b0) begin
            tests_failed++; $display("FAIL mis_flush got req=%b stall=%b adel=%b want 0/1/0", inst_req, stall_o, adel_o); end
        tick();
        tests_run++; if (adel_o !== 1'b1 || inst_o !== NOP || stall_o !== 1'b0 || inst_req !== 1'b0) begin
            tests_failed++; $display("FAIL mis_done got adel=%b inst=%h stall=%b req=%b want 1/%h/0/0",
                                     adel_o, inst_o, stall_o, inst_req, NOP); end
        adv_i = 1'b1; pc_i = 32'hbfc0_0004; tick(); adv_i = 1'b0;
        tests_run++; if (adel_o !== 1'b0 || inst_req !== 1'b1 || stall_o !== 1'b1) begin
            tests_failed++; $display("FAIL mis_leave got adel=%b req=%b stall=%b want 0/1/1", adel_o, inst_req, stall_o); end
`else
        tests_run++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0000 || adel_o !== 1'b0) begin
            tests_failed++; $display("FAIL mis_forced got req=%b addr=%h adel=%b want 1/bfc00000/0", inst_req, inst_addr, adel_o); end
        inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678; tick(); inst_data_ok = 1'b0;
        tests_run++; if (inst_o !== 32'h1234_5678 || adel_o !== 1'b0 || stall_o !== 1'b0) begin
            tests_failed++; $display("FAIL mis_deliver got inst=%h adel=%b stall=%b want 12345678/0/0", inst_o, adel_o, stall_o); end
        adv_i = 1'b1; pc_i = 32'hbfc0_0004; tick(); adv_i = 1'b0;
`endif
    endtask

    task automatic test_random();
        int bad_stall = 0, bad_req = 0, bad_inst = 0, bad_hold = 0, bad_next = 0, timeouts = 0;
        for (int n = 0; n < 30; n++) begin
            int alat = $urandom_range(0, 3);
            int dlat = $urandom_range(1, 3);
            int hold = $urandom_range(0, 3);
            int req_cyc = 0, stall_cyc = 0, hs = 0, wait_cyc = 0;
            logic [31:0] d = $urandom;
            logic [31:0] np = $urandom;
`ifdef INST_ALIGN_CHECK_EN
            np = np & 32'hFFFF_FFFC;
`endif
            for (int c = 0; c < 20; c++) begin
                if (!stall_o) break;
                stall_cyc++;
                if (inst_req) begin
                    req_cyc++;
                    if (inst_addr !== (pc_i & 32'hFFFF_FFFC)) bad_req++;
                    inst_addr_ok = (req_cyc == alat + 1);
                    inst_data_ok = 1'b0;
                    if (inst_addr_ok) hs++;
                end else begin
                    inst_addr_ok = 1'b0;
                    if (hs == 1) wait_cyc++;
                    inst_data_ok = (hs == 1 && wait_cyc == dlat);
                    inst_rdata   = inst_data_ok ? d : $urandom;
                end
                tick();
            end
            inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
            if (stall_o !== 1'b0) timeouts++;
            if (stall_cyc != alat + 1 + dlat) bad_stall++;
            if (req_cyc != alat + 1 || hs != 1) bad_req++;
            if (inst_o !== d) bad_inst++;
            for (int h = 0; h < hold; h++) begin
                tick();
                if (inst_o !== d || stall_o !== 1'b0 || inst_req !== 1'b0) bad_hold++;
            end
            adv_i = 1'b1; pc_i = np; tick(); adv_i = 1'b0;
            if (inst_req !== 1'b1 || inst_addr !== (np & 32'hFFFF_FFFC) || inst_o !== NOP) bad_next++;
        end
        tests_run++; if (timeouts != 0) begin tests_failed++; $display("FAIL rnd_timeout got %0d want 0", timeouts); end
        tests_run++; if (bad_stall != 0) begin tests_failed++; $display("FAIL rnd_stall got %0d bad want 0", bad_stall); end
        tests_run++; if (bad_req != 0) begin tests_failed++; $display("FAIL rnd_req got %0d bad want 0", bad_req); end
        tests_run++; if (bad_inst != 0) begin tests_failed++; $display("FAIL rnd_inst got %0d bad want 0", bad_inst); end
        tests_run++; if (bad_hold != 0) begin tests_failed++; $display("FAIL rnd_hold got %0d bad want 0", bad_hold); end
        tests_run++; if (bad_next != 0) begin tests_failed++; $display("FAIL rnd_next got %0d bad want 0", bad_next); end
    endtask

    task automatic test_reset_mid();
        // reset while requesting: request drops at once
        resetn = 1'b0; #1;
        tests_run++; if (inst_req !== 1'b0) begin tests_failed++; $display("FAIL rm_req got %b want 0", inst_req); end
        tick(); resetn = 1'b1; tick();
        tests_run++; if (inst_req !== 1'b1) begin tests_failed++; $display("FAIL rm_restart1 got %b want 1", inst_req); end
        // reset while waiting
        inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
        resetn = 1'b0; #1;
        tests_run++; if (inst_req !== 1'b0 || inst_o !== NOP || stall_o !== 1'b1) begin
            tests_failed++; $display("FAIL rm_wait got req=%b inst=%h stall=%b want 0/%h/1", inst_req, inst_o, stall_o, NOP); end
        tick(); resetn = 1'b1;
        tests_run++; if (inst_req !== 1'b0) begin tests_failed++; $display("FAIL rm_idle got %b want 0", inst_req); end
        tick();
        tests_run++; if (inst_req !== 1'b1) begin tests_failed++; $display("FAIL rm_restart2 got %b want 1", inst_req); end
        // reset while holding a word
        inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'h5555_AAAA; tick(); inst_data_ok = 1'b0;
        resetn = 1'b0; #1;
        tests_run++; if (inst_o !== NOP || stall_o !== 1'b1) begin
            tests_failed++; $display("FAIL rm_done got inst=%h stall=%b want %h/1", inst_o, stall_o, NOP); end
        tick(); resetn = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_delayed();
        test_hold();
        test_spurious_data_ok();
        test_flush();
        test_misalign();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound so a stuck run still ends with a report
    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
